// File: rtl/des_pkg.sv
// Shared definitions for the DES S-box scheduler: FIPS 46-3 S-box tables,
// box-to-bit-slice helpers and the scheduler state encoding.
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // SBOX[box][row][col], box 0 = S1. Each row is written as 16 nibbles with
  // column 0 leftmost, so the hex literals read like the published tables.
  localparam logic [0:15][3:0] SBOX [8][4] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

  // 6-bit input slice of box b (0-based): b=0 -> [47:42], b=7 -> [5:0].
  function automatic logic [5:0] box_bits(input logic [47:0] d, input logic [2:0] b);
    logic [47:0] s;
    s = d >> (6'd42 - 6'(b) * 6'd6);
    return s[5:0];
  endfunction

  // Replace output nibble of box b (0-based): b=0 -> [31:28], b=7 -> [3:0].
  function automatic logic [31:0] put_nibble(input logic [31:0] w, input logic [2:0] b,
                                             input logic [3:0] n);
    logic [4:0]  sh;
    logic [31:0] m;
    sh = 5'd28 - 5'(b) * 5'd4;
    m  = 32'hF << sh;
    return (w & ~m) | (32'(n) << sh);
  endfunction

endpackage

// File: rtl/des_sbox_rom.sv
// One combinational S-box lane: sel picks the box (0 = S1), addr is the 6-bit
// post-key-mix slice, row = {addr[5], addr[0]}, column = addr[4:1].
module des_sbox_rom
  import des_pkg::*;
(
  input  logic [2:0] sel,
  input  logic [5:0] addr,
  output logic [3:0] sout
);

  assign sout = SBOX[sel][{addr[5], addr[0]}][addr[4:1]];

endmodule

// File: rtl/des_sbox_sched.sv
// Time-multiplexed DES S-box substitution: one 48-bit word in, eight lookups
// spread over 8/LANES cycles on shared ROM lanes, one 32-bit word out.
module des_sbox_sched
  import des_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output state_t      dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid must hold with stable data until then, and both ready
  // and valid here depend only on the registered state.

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_lanes_check
    $error("des_sbox_sched: LANES must be 1, 2, 4 or 8");
  end

  localparam int         G        = 8 / LANES;
  localparam logic [2:0] GRP_LAST = 3'(G - 1);

  state_t      state_q, state_d;
  logic [2:0]  grp_q, grp_d;
  logic [47:0] in_q;
  logic [31:0] out_q, out_d;

  logic [2:0]  sel [LANES];
  logic [3:0]  nib [LANES];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign sel[j] = 3'(int'(grp_q) * LANES + j);

    des_sbox_rom u_rom (
      .sel  (sel[j]),
      .addr (box_bits(in_q, sel[j])),
      .sout (nib[j])
    );
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_LOOKUP;
          grp_d   = 3'd0;
        end
      end
      ST_LOOKUP: begin
        for (int j = 0; j < LANES; j++) begin
          out_d = put_nibble(out_d, sel[j], nib[j]);
        end
        // grp goes back to 0 on the last group so it never runs past G-1.
        if (grp_q == GRP_LAST) begin
          state_d = ST_DONE;
          grp_d   = 3'd0;
        end else begin
          grp_d = grp_q + 3'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grp_q   <= 3'd0;
      in_q    <= 48'h0;
      out_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      out_q   <= out_d;
      if (state_q == ST_IDLE && in_valid) begin
        in_q <= in_data;
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_des_sbox_sched.sv
// Bench for des_sbox_sched: one instance per legal LANES value, directed
// vectors, backpressure and reset corner cases, and random traffic.
module tb_des_sbox_sched;
  import des_pkg::*;

  localparam int NWORDS = 1000;
  localparam int MAXC   = 30000;

  logic        clk;
  logic        rst;
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [47:0] in_data   [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic [31:0] out_data  [4];
  state_t      dbg_state [4];

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [4][$];

  // Published FIPS 46-3 tables, row-major: entry = row*16 + col.
  int sb_tab [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  typedef struct {
    int          inst;
    logic [47:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_sched #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .dbg_state (dbg_state[g])
    );
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sbox_model(input logic [47:0] d);
    logic [31:0] r = 32'h0;
    for (int k = 0; k < 8; k++) begin
      int a   = int'((d >> (42 - 6 * k)) & 48'h3F);
      int row = (a / 32) * 2 + (a % 2);
      int col = (a / 2) % 16;
      r = (r << 4) | 32'(sb_tab[k][row * 16 + col]);
    end
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom), $urandom};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: one word through instance i with out_ready high. lat counts
  // rising edges from the accept edge to the edge at which out_valid is
  // first seen high (the handshake edge); -1 means the bound expired.
  task automatic run_word(input int i, input logic [47:0] d,
                          output logic [31:0] res, output int lat);
    int k;
    @(negedge clk);
    in_valid[i]  = 1'b1;
    in_data[i]   = d;
    out_ready[i] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
    in_data[i]  = rand48();
    k = 0;
    lat = -1;
    res = 32'h0;
    while (k < 40) begin
      @(negedge clk);
      if (out_valid[i]) begin
        lat = k + 1;
        res = out_data[i];
        break;
      end
      k++;
    end
    @(negedge clk);
    chk($sformatf("ready_after_hs[%0d]", i), 32'(in_ready[i]), 32'd1);
  endtask

  task automatic rand_drive(input int i);
    logic [47:0] d;
    int w;
    for (int n = 0; n < NWORDS; n++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid[i] = 1'b0;
        in_data[i]  = rand48();
        @(negedge clk);
      end
      d = rand48();
      in_valid[i] = 1'b1;
      in_data[i]  = d;
      w = 0;
      while (!in_ready[i] && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready[i]) begin
        chk($sformatf("accept_timeout[%0d]", i), 32'd0, 32'd1);
        in_valid[i] = 1'b0;
        return;
      end
      exp_q[i].push_back(sbox_model(d));
      @(negedge clk);
    end
    in_valid[i] = 1'b0;
  endtask

  // Scoreboard side: random out_ready, compare in order, and check that a
  // stalled result is held stable.
  task automatic rand_mon(input int i);
    int got = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [31:0] held = 32'h0;
    while (got < NWORDS && cyc < MAXC) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk($sformatf("stall_valid[%0d]", i), 32'(out_valid[i]), 32'd1);
        chk($sformatf("stall_data[%0d]", i), out_data[i], held);
      end
      out_ready[i] = ($urandom_range(0, 3) != 0);
      stalled = out_valid[i] && !out_ready[i];
      held    = out_data[i];
      if (out_valid[i] && out_ready[i]) begin
        if (exp_q[i].size() == 0) begin
          chk($sformatf("unexpected_word[%0d]", i), out_data[i], 32'h0);
          errors += (out_data[i] == 32'h0) ? 1 : 0;
        end else begin
          chk($sformatf("rand_data[%0d]", i), out_data[i], exp_q[i].pop_front());
        end
        got++;
      end
    end
    chk($sformatf("rand_count[%0d]", i), 32'(got), 32'(NWORDS));
    @(negedge clk);
    out_ready[i] = 1'b0;
  endtask

  task automatic rand_run(input int i);
    fork
      rand_drive(i);
      rand_mon(i);
    join
    chk($sformatf("queue_empty[%0d]", i), 32'(exp_q[i].size()), 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    logic [47:0] d;
    int lat;
    int k;

    vecs[0]  = '{0, 48'h000000000000, 32'hEFA72C4D};
    vecs[1]  = '{3, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
    vecs[2]  = '{1, 48'h000000000000, 32'hEFA72C4D};
    vecs[3]  = '{2, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
    vecs[4]  = '{1, 48'h040000000000, 32'h0FA72C4D};
    vecs[5]  = '{2, 48'h001000000000, 32'hE3A72C4D};
    vecs[6]  = '{3, 48'h000040000000, 32'hEFD72C4D};
    vecs[7]  = '{0, 48'h000001000000, 32'hEFAD2C4D};
    vecs[8]  = '{1, 48'h000000040000, 32'hEFA7EC4D};
    vecs[9]  = '{2, 48'h000000001000, 32'hEFA72A4D};
    vecs[10] = '{3, 48'h000000000040, 32'hEFA72CDD};
    vecs[11] = '{0, 48'h000000000001, 32'hEFA72C41};

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = 48'h0;
      out_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_in_ready[%0d]", i), 32'(in_ready[i]), 32'd1);
      chk($sformatf("rst_out_valid[%0d]", i), 32'(out_valid[i]), 32'd0);
      chk($sformatf("rst_out_data[%0d]", i), out_data[i], 32'h0);
      chk($sformatf("rst_state[%0d]", i), 32'(dbg_state[i]), 32'(ST_IDLE));
    end

    // Directed vectors, including per-box isolation.
    for (int v = 0; v < 12; v++) begin
      run_word(vecs[v].inst, vecs[v].din, res, lat);
      chk($sformatf("vec%0d_data", v), res, vecs[v].exp);
      chk($sformatf("vec%0d_model", v), res, sbox_model(vecs[v].din));
      chk($sformatf("vec%0d_lat", v), 32'(lat), 32'((8 >> vecs[v].inst) + 1));
    end

    // Backpressure on LANES=1: result held, in_ready low, in_valid ignored.
    d = rand48();
    @(negedge clk);
    in_valid[0]  = 1'b1;
    in_data[0]   = d;
    out_ready[0] = 1'b0;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    k = 0;
    while (!out_valid[0] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("bp_reach_done", 32'(out_valid[0]), 32'd1);
    held = out_data[0];
    chk("bp_data", held, sbox_model(d));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid[0] = (c % 3 == 0);
      in_data[0]  = rand48();
      chk("bp_hold_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_hold_ready", 32'(in_ready[0]), 32'd0);
      chk("bp_hold_data", out_data[0], held);
    end
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready[0]), 32'd1);
    chk("bp_release_valid", 32'(out_valid[0]), 32'd0);

    // Reset four edges into LOOKUP on LANES=1, then a fresh all-zero word.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 48'hFFFFFFFFFFFF;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("mid_rst_out_data", out_data[0], 32'h0);
    chk("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_word(0, 48'h0, res, lat);
    chk("post_rst_data", res, 32'hEFA72C4D);
    chk("post_rst_lat", 32'(lat), 32'd9);

    // Random traffic on all four instances concurrently.
    @(negedge clk);
    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
      rand_run(3);
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_sbox_sched.md
# des_sbox_sched

Time-multiplexed S-box substitution scheduler for the DES round function. It accepts one 48-bit post-expansion/post-key-XOR word and sequences the eight 6-to-4 S-box lookups through a parameterised number of shared ROM lanes. It assembles the 32-bit substitution result and hands it downstream over a valid/ready handshake. It sits between the key-mix XOR and the P-permutation, trading area (fewer ROM instances) against round latency.

## Interface
- LANES, 1, number of shared S-box ROM lanes used per cycle; legal values 1, 2, 4, 8; any other value is a synthesis-time error.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word.
- in_data  in  48  S-box input; box k (k=1..8) uses bits [53-6k : 48-6k], so S1 uses [47:42] and S8 uses [5:0].
- out_valid  out  1  out_data holds a complete result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  32  substitution result; box k drives nibble [35-4k : 32-4k], so S1 drives [31:28].

## Operation
- Lookup rule for each box: row = {a[5], a[0]}, col = a[4:1]; the output is the standard FIPS 46-3 Sk entry.
- Define G = 8/LANES lookup groups per word.
- State machine:
  - IDLE: in_ready=1. When in_valid is high, capture in_data into the input register, set grp=0, go to LOOKUP.
  - LOOKUP: in_ready=0. Each cycle, lanes j=0..LANES-1 look up box grp*LANES+j+1 and write the nibbles into the out_data register. Then grp increments. After the group where grp==G-1, go to DONE.
  - DONE: out_valid=1. out_data and out_valid are held stable until out_ready is high; on that handshake, go to IDLE.
- out_data nibbles not yet written for the current word keep their previous contents. Only DONE exposes out_valid, so partial results are never visible.
- in_data is sampled only at the accept edge. Changes to in_data after acceptance have no effect.
- Arithmetic: grp is a 3-bit unsigned counter. It never wraps past G-1, because the FSM leaves LOOKUP at G-1.
- in_ready is decoded from the registered state only. There is no combinational path from out_ready or in_valid to in_ready or out_valid.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=32'h0, grp=0, input register 0.
- Latency: accept at edge E; out_valid rises at edge E+G+1. For LANES=1 that is E+9; for LANES=8 it is E+2.
- Throughput: at best one word per G+2 cycles, with out_ready held high. in_ready returns the cycle after the out handshake.
- Backpressure: with out_ready low, the block remains in DONE indefinitely. in_ready stays 0 and out_data is stable.
- Reset mid-operation (LOOKUP or DONE): outputs return to their reset values immediately. The partial word is discarded, and the first accept after reset release starts a fresh word.
- in_valid asserted during LOOKUP or DONE is ignored. No word is lost, because the upstream must hold in_valid until in_ready.

## Structure
- Shared package des_pkg holds:
  - the eight S-box tables as a constant array indexed [box][row][col];
  - the box-index-to-bit-slice helper functions for the 48-bit input and the 32-bit output;
  - the state enum.
- Sub-module des_sbox_rom is combinational. It has inputs sel[2:0] (box select) and addr[5:0], and output sout[3:0]. It is instantiated LANES times.
- The scheduler contains only the FSM, the grp counter, the input register and the output register.

## Test plan
- All-zero input, LANES=1: in_data=48'h0 -> out_data=32'hEFA72C4D, with out_valid rising exactly 9 cycles after the accept edge.
- All-ones input, LANES=8: in_data=48'hFFFFFFFFFFFF -> out_data=32'hD9CE3DCB, with out_valid at accept+2.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data constant, in_ready=0 throughout, and in_valid pulses ignored. Release -> in_ready=1 on the next cycle.
- Reset mid-LOOKUP (LANES=1, rst asserted 4 cycles after accept) -> out_valid=0, out_data=0, and in_ready=1 immediately. A subsequent all-zero word yields 32'hEFA72C4D.
- Randomised 1000 words for each of LANES = 1, 2, 4, 8 with random in_valid/out_ready stalls -> out_data matches a reference S-box model in order, with no drops or duplicates.
- Per-box isolation: in_data with box k's 6 bits = 6'b000001 (row 1, col 0) and all other boxes zero -> nibble k equals the row-1 col-0 entry of Sk (S2 gives 3), and the other nibbles equal the all-zero values.
